// File: rtl/mul_array_pipe_pkg.sv
// Shared single-precision field layout, widths and pipeline metadata
// for the Goldschmidt multiplier datapath.
package mul_array_pipe_pkg;

    localparam int FLOAT_W       = 32;
    localparam int SIG_W         = 24;
    localparam int PROD_W        = 48;
    localparam int EXP_W         = 11;
    localparam int EXP_BIAS_IEEE = 127;
    localparam logic [7:0] EXP_INF = 8'hFF;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } float_t;

    // Sign, biased exponent and special-case flags that ride alongside the partial products
    typedef struct packed {
        logic                    sign;
        logic signed [EXP_W-1:0] exp;
        logic                    zero;
        logic                    inf;
    } meta_t;

    function automatic logic [SIG_W-1:0] significand(input float_t f);
        return {f.exp != 8'd0, f.frac};
    endfunction

endpackage

// File: rtl/mul_array_pipe_if.sv
// Operand taps from the input FIFO plus the product/status returned to the divider.
interface mul_array_pipe_if;
    import mul_array_pipe_pkg::*;

    logic               in_valid;
    logic [FLOAT_W-1:0] stage0_a;
    logic [FLOAT_W-1:0] stage0_b;
    logic [FLOAT_W-1:0] stage1_a;
    logic [FLOAT_W-1:0] stage1_b;
    logic [FLOAT_W-1:0] stage2_a;
    logic [FLOAT_W-1:0] stage2_b;
    logic [FLOAT_W-1:0] p_out;
    logic               p_valid;
    logic               sync_err;

    modport master (
        output in_valid, stage0_a, stage0_b, stage1_a, stage1_b, stage2_a, stage2_b,
        input  p_out, p_valid, sync_err
    );

    modport slave (
        input  in_valid, stage0_a, stage0_b, stage1_a, stage1_b, stage2_a, stage2_b,
        output p_out, p_valid, sync_err
    );

endinterface

// File: rtl/mul_array_pipe_pp_slice.sv
// One partial-product stage: registers acc_in + (a * b_slice << SHIFT) with its valid bit.
module mul_array_pipe_pp_slice
    import mul_array_pipe_pkg::*;
#(
    parameter int W         = 10,
    parameter int ACC_IN_W  = 1,
    parameter int ACC_OUT_W = 34,
    parameter int SHIFT     = 0
) (
    input  logic                 clk,
    input  logic                 clear_b,
    input  logic [SIG_W-1:0]     a,
    input  logic [W-1:0]         b,
    input  logic [ACC_IN_W-1:0]  acc_in,
    input  logic                 valid_in,
    output logic [ACC_OUT_W-1:0] acc_out,
    output logic                 valid_out
);

    logic [SIG_W+W-1:0]   prod;
    logic [ACC_OUT_W-1:0] acc_next;
    logic [ACC_OUT_W-1:0] acc_reg;
    logic                 valid_reg;

    assign prod     = {{W{1'b0}}, a} * {{SIG_W{1'b0}}, b};
    assign acc_next = ACC_OUT_W'(acc_in) + (ACC_OUT_W'(prod) << SHIFT);

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            acc_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= valid_in;
            if (valid_in) begin
                acc_reg <= acc_next;
            end
        end
    end

    assign acc_out   = acc_reg;
    assign valid_out = valid_reg;

endmodule

// File: rtl/mul_array_pipe.sv
// 3-stage significand array multiplier with exponent/flag pipeline, operand
// consistency checking and a normalise/pack output register (4-cycle latency).
module mul_array_pipe
    import mul_array_pipe_pkg::*;
#(
    parameter int W_LO     = 10,
    parameter int W_MID    = 10,
    parameter int W_HI     = 4,
    parameter int EXP_BIAS = EXP_BIAS_IEEE
) (
    input  logic             clk,
    input  logic             clear_b,
    mul_array_pipe_if.slave  bus
);

    localparam int ACC1_W = SIG_W + W_LO;
    localparam int ACC2_W = SIG_W + W_LO + W_MID;

    generate
        if (W_LO + W_MID + W_HI != SIG_W) begin : g_split_check
            $error("b significand slices must add up to 24 bits");
        end
    endgenerate

    float_t fa0, fb0, fa1, fb1, fa2, fb2;
    logic [SIG_W-1:0] ma0, mb0, ma1, mb1, ma2, mb2;

    assign fa0 = bus.stage0_a;
    assign fb0 = bus.stage0_b;
    assign fa1 = bus.stage1_a;
    assign fb1 = bus.stage1_b;
    assign fa2 = bus.stage2_a;
    assign fb2 = bus.stage2_b;

    assign ma0 = significand(fa0);
    assign mb0 = significand(fb0);
    assign ma1 = significand(fa1);
    assign mb1 = significand(fb1);
    assign ma2 = significand(fa2);
    assign mb2 = significand(fb2);

    logic [ACC1_W-1:0] acc1;
    logic [ACC2_W-1:0] acc2;
    logic [PROD_W-1:0] acc3;
    logic              v1, v2, v3;

    mul_array_pipe_pp_slice #(
        .W(W_LO), .ACC_IN_W(1), .ACC_OUT_W(ACC1_W), .SHIFT(0)
    ) u_slice_lo (
        .clk(clk), .clear_b(clear_b),
        .a(ma0), .b(mb0[W_LO-1:0]), .acc_in(1'b0), .valid_in(bus.in_valid),
        .acc_out(acc1), .valid_out(v1)
    );

    mul_array_pipe_pp_slice #(
        .W(W_MID), .ACC_IN_W(ACC1_W), .ACC_OUT_W(ACC2_W), .SHIFT(W_LO)
    ) u_slice_mid (
        .clk(clk), .clear_b(clear_b),
        .a(ma1), .b(mb1[W_LO+W_MID-1:W_LO]), .acc_in(acc1), .valid_in(v1),
        .acc_out(acc2), .valid_out(v2)
    );

    mul_array_pipe_pp_slice #(
        .W(W_HI), .ACC_IN_W(ACC2_W), .ACC_OUT_W(PROD_W), .SHIFT(W_LO + W_MID)
    ) u_slice_hi (
        .clk(clk), .clear_b(clear_b),
        .a(ma2), .b(mb2[SIG_W-1:W_LO+W_MID]), .acc_in(acc2), .valid_in(v2),
        .acc_out(acc3), .valid_out(v3)
    );

    // Only part of each significand feeds a given slice; truncated product LSBs are discarded
    logic unused_bits;
    assign unused_bits = ^{mb0[SIG_W-1:W_LO], mb1[W_LO-1:0], mb1[SIG_W-1:W_LO+W_MID],
                           mb2[W_LO+W_MID-1:0], acc3[22:0]};

    meta_t             s1_meta_next;
    meta_t             s1_meta_reg, s2_meta_reg, s3_meta_reg;
    logic [FLOAT_W-1:0] s1_a_reg, s1_b_reg, s2_a_reg, s2_b_reg;
    logic              sync_err_next, sync_err_reg;
    logic [FLOAT_W-1:0] p_out_next, p_out_reg;
    logic              p_valid_reg;

    always_comb begin
        s1_meta_next      = '0;
        s1_meta_next.sign = fa0.sign ^ fb0.sign;
        s1_meta_next.exp  = EXP_W'({3'b000, fa0.exp}) + EXP_W'({3'b000, fb0.exp})
                          - EXP_W'(EXP_BIAS);
        s1_meta_next.zero = (fa0.exp == 8'd0) || (fb0.exp == 8'd0);
        s1_meta_next.inf  = (fa0.exp == EXP_INF) || (fb0.exp == EXP_INF);
    end

    // Taps must match the copy captured when the pair entered; mismatch latches until reset
    always_comb begin
        sync_err_next = sync_err_reg;
        if (v1 && ((bus.stage1_a != s1_a_reg) || (bus.stage1_b != s1_b_reg))) begin
            sync_err_next = 1'b1;
        end
        if (v2 && ((bus.stage2_a != s2_a_reg) || (bus.stage2_b != s2_b_reg))) begin
            sync_err_next = 1'b1;
        end
    end

    logic signed [EXP_W-1:0] exp_adj;
    logic [22:0]             man;

    always_comb begin
        exp_adj    = s3_meta_reg.exp + (acc3[PROD_W-1] ? 11'sd1 : 11'sd0);
        man        = acc3[PROD_W-1] ? acc3[46:24] : acc3[45:23];
        p_out_next = {s3_meta_reg.sign, exp_adj[7:0], man};
        if (s3_meta_reg.zero) begin
            p_out_next = {s3_meta_reg.sign, 31'b0};
        end else if (s3_meta_reg.inf) begin
            p_out_next = {s3_meta_reg.sign, EXP_INF, 23'b0};
        end else if (exp_adj >= 11'sd255) begin
            p_out_next = {s3_meta_reg.sign, EXP_INF, 23'b0};
        end else if (exp_adj <= 11'sd0) begin
            p_out_next = {s3_meta_reg.sign, 31'b0};
        end
    end

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            s1_meta_reg  <= '0;
            s2_meta_reg  <= '0;
            s3_meta_reg  <= '0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s2_a_reg     <= '0;
            s2_b_reg     <= '0;
            sync_err_reg <= 1'b0;
            p_out_reg    <= '0;
            p_valid_reg  <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                s1_meta_reg <= s1_meta_next;
                s1_a_reg    <= bus.stage0_a;
                s1_b_reg    <= bus.stage0_b;
            end
            if (v1) begin
                s2_meta_reg <= s1_meta_reg;
                s2_a_reg    <= s1_a_reg;
                s2_b_reg    <= s1_b_reg;
            end
            if (v2) begin
                s3_meta_reg <= s2_meta_reg;
            end
            sync_err_reg <= sync_err_next;
            p_valid_reg  <= v3;
            if (v3) begin
                p_out_reg <= p_out_next;
            end
        end
    end

    assign bus.p_out    = p_out_reg;
    assign bus.p_valid  = p_valid_reg;
    assign bus.sync_err = sync_err_reg;

endmodule

// File: tb/tb_mul_array_pipe.sv
// Self-checking bench: FIFO-style tap model plus a full-width float multiply reference.
module tb_mul_array_pipe;
    import mul_array_pipe_pkg::*;

    logic clk = 1'b0;
    logic clear_b;
    always #5 clk = ~clk;

    mul_array_pipe_if bus();

    mul_array_pipe #(.W_LO(10), .W_MID(10), .W_HI(4), .EXP_BIAS(127)) dut (
        .clk(clk), .clear_b(clear_b), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic        mv [4];
    logic [31:0] mp [4];
    logic [31:0] exp_out;
    logic        exp_sync;
    logic [31:0] h1_a, h1_b, h2_a, h2_b;

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'b0};
        p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {s, 8'hFF, 23'b0};
        if (e <= 0) return {s, 31'b0};
        return {s, 8'(e), m};
    endfunction

    function automatic logic [31:0] rand_float(input bit specials);
        logic [7:0] e;
        int k;
        k = specials ? $urandom_range(0, 9) : 9;
        case (k)
            0:       e = 8'd0;
            1:       e = 8'hFF;
            2:       e = 8'd1;
            3:       e = 8'd254;
            default: e = 8'($urandom_range(64, 190));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0;
            mp[i] = '0;
        end
        exp_out  = '0;
        exp_sync = 1'b0;
        h1_a = '0; h1_b = '0; h2_a = '0; h2_b = '0;
    endtask

    // Drives one cycle; corrupt=1 flips stage1_a, corrupt=2 flips stage2_b
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input int corrupt);
        bus.in_valid = v;
        bus.stage0_a = v ? a : $urandom;
        bus.stage0_b = v ? b : $urandom;
        bus.stage1_a = h1_a ^ ((corrupt == 1) ? 32'h1 : 32'h0);
        bus.stage1_b = h1_b;
        bus.stage2_a = h2_a;
        bus.stage2_b = h2_b ^ ((corrupt == 2) ? 32'h2 : 32'h0);
        if (corrupt == 1 && mv[0]) exp_sync = 1'b1;
        if (corrupt == 2 && mv[1]) exp_sync = 1'b1;
        @(posedge clk);
        #1;
        h2_a = h1_a; h2_b = h1_b;
        h1_a = bus.stage0_a; h1_b = bus.stage0_b;
        for (int i = 3; i > 0; i--) begin
            mv[i] = mv[i-1];
            mp[i] = mp[i-1];
        end
        mv[0] = v;
        mp[0] = ref_mul(a, b);
        if (mv[3]) exp_out = mp[3];
        cyc++;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.p_out !== 32'h0) begin errors++; $display("FAIL reset_p_out got %h exp 00000000", bus.p_out); end
        checks++;
        if (bus.p_valid !== 1'b0) begin errors++; $display("FAIL reset_p_valid got %b exp 0", bus.p_valid); end
        checks++;
        if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err got %b exp 0", bus.sync_err); end
        step(1'b0, 0, 0, 0);
        step(1'b0, 0, 0, 0);
        clear_b = 1'b1;
        step(1'b0, 0, 0, 0);
        checks++;
        if (bus.p_valid !== 1'b0) begin errors++; $display("FAIL post_release_p_valid got %b exp 0", bus.p_valid); end
        $display("reset: p_out=%h p_valid=%b sync_err=%b", bus.p_out, bus.p_valid, bus.sync_err);
    endtask

    task automatic test_directed();
        logic [31:0] ta [6] = '{32'h3FC00000, 32'h40400000, 32'hC0000000, 32'h00000000, 32'h7F000000, 32'h00800000};
        logic [31:0] tb [6] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h40400000, 32'h7F000000, 32'h00800000};
        logic [31:0] te [6] = '{32'h40400000, 32'h41100000, 32'hC0C00000, 32'h00000000, 32'h7F800000, 32'h00000000};
        for (int n = 0; n < 6; n++) begin
            step(1'b1, ta[n], tb[n], 0);
            for (int k = 0; k < 4; k++) begin
                if (k > 0) step(1'b0, 0, 0, 0);
                checks++;
                if (bus.p_valid !== (k == 3)) begin
                    errors++;
                    $display("FAIL directed_latency vec %0d cyc+%0d p_valid got %b exp %b", n, k + 1, bus.p_valid, k == 3);
                end
            end
            checks++;
            if (bus.p_out !== te[n]) begin
                errors++;
                $display("FAIL directed_product %h*%h got %h exp %h", ta[n], tb[n], bus.p_out, te[n]);
            end
            $display("directed: %h * %h -> %h", ta[n], tb[n], bus.p_out);
            step(1'b0, 0, 0, 0);
            checks++;
            if (bus.p_valid !== 1'b0 || bus.p_out !== te[n]) begin
                errors++;
                $display("FAIL directed_hold vec %0d got %b/%h exp 0/%h", n, bus.p_valid, bus.p_out, te[n]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic pat [12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            step(pat[i], rand_float(1'b0), rand_float(1'b0), 0);
            checks++;
            if (bus.p_valid !== mv[3]) begin
                errors++;
                $display("FAIL b2b_p_valid cyc %0d got %b exp %b", cyc, bus.p_valid, mv[3]);
            end
            checks++;
            if (bus.p_out !== exp_out) begin
                errors++;
                $display("FAIL b2b_p_out cyc %0d got %h exp %h", cyc, bus.p_out, exp_out);
            end
            checks++;
            if (bus.sync_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_sync_err cyc %0d got %b exp 0", cyc, bus.sync_err);
            end
            if (bus.p_valid) $display("b2b: cyc %0d p_out=%h", cyc, bus.p_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            step(($urandom_range(0, 9) < 7) && (i < 74), rand_float(1'b1), rand_float(1'b1), 0);
            checks++;
            if (bus.p_valid !== mv[3] || bus.p_out !== exp_out) begin
                errors++;
                $display("FAIL random_out cyc %0d got %b/%h exp %b/%h", cyc, bus.p_valid, bus.p_out, mv[3], exp_out);
            end
            checks++;
            if (bus.sync_err !== exp_sync) begin
                errors++;
                $display("FAIL random_sync_err cyc %0d got %b exp %b", cyc, bus.sync_err, exp_sync);
            end
            if (bus.p_valid) $display("random: cyc %0d p_out=%h", cyc, bus.p_out);
        end
    endtask

    task automatic test_sync_err();
        step(1'b1, rand_float(1'b0), rand_float(1'b0), 0);
        checks++;
        if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL sync1_before got %b exp 0", bus.sync_err); end
        step(1'b0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step(1'b0, 0, 0, 0);
            checks++;
            if (bus.sync_err !== exp_sync) begin
                errors++;
                $display("FAIL sync1_sticky cyc %0d got %b exp %b", cyc, bus.sync_err, exp_sync);
            end
        end
        $display("sync_err stage1: sync_err=%b", bus.sync_err);
    endtask

    task automatic test_reset_midflight();
        step(1'b1, rand_float(1'b0), rand_float(1'b0), 0);
        step(1'b1, rand_float(1'b0), rand_float(1'b0), 0);
        #3;
        clear_b = 1'b0;
        #1;
        checks++;
        if (bus.p_out !== 32'h0 || bus.p_valid !== 1'b0 || bus.sync_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async got %h/%b/%b exp 00000000/0/0", bus.p_out, bus.p_valid, bus.sync_err);
        end
        @(posedge clk);
        #1;
        model_clear();
        step(1'b0, 0, 0, 0);
        clear_b = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 0, 0, 0);
            checks++;
            if (bus.p_valid !== 1'b0 || bus.p_out !== 32'h0) begin
                errors++;
                $display("FAIL midreset_drop cyc %0d got %b/%h exp 0/00000000", cyc, bus.p_valid, bus.p_out);
            end
        end
        $display("reset mid-flight: p_out=%h p_valid=%b sync_err=%b", bus.p_out, bus.p_valid, bus.sync_err);
    endtask

    task automatic test_sync_stage2();
        step(1'b1, rand_float(1'b0), rand_float(1'b0), 0);
        step(1'b0, 0, 0, 0);
        checks++;
        if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL sync2_before got %b exp 0", bus.sync_err); end
        step(1'b0, 0, 0, 2);
        checks++;
        if (bus.sync_err !== exp_sync) begin errors++; $display("FAIL sync2_set got %b exp %b", bus.sync_err, exp_sync); end
        step(1'b0, 0, 0, 0);
        checks++;
        if (bus.p_valid !== 1'b1 || bus.sync_err !== 1'b1) begin
            errors++;
            $display("FAIL sync2_drain got %b/%b exp 1/1", bus.p_valid, bus.sync_err);
        end
        $display("sync_err stage2: sync_err=%b", bus.sync_err);
    endtask

    initial begin
        clear_b      = 1'b0;
        bus.in_valid = 1'b0;
        bus.stage0_a = '0; bus.stage0_b = '0;
        bus.stage1_a = '0; bus.stage1_b = '0;
        bus.stage2_a = '0; bus.stage2_b = '0;
        model_clear();
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_sync_err();
        test_reset_midflight();
        test_sync_stage2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
